piso_serializer: RTL and testbench

Parallel-in, serial-out serializer that sits directly upstream of the 4-bit SIPO shift register. It accepts a parallel word over a valid/ready handshake and shifts it out MSB-first, one bit per clock. It marks each valid bit and signals word completion, so the downstream SIPO holds the word in its original bit order after WIDTH shifts. A configurable idle gap separates consecutive words.

---
 rtl/piso_pkg.sv | 21 ++
 rtl/piso_serializer.sv | 107 ++++++++++
 tb/tb_piso_serializer.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/piso_pkg.sv
// Shared definitions for the parallel-in / serial-out serializer feeding the 4-bit SIPO.
package piso_pkg;

    // Default word width; matches the downstream SIPO.
    localparam int SER_WIDTH = 4;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_SHIFT = 2'd1;
    localparam state_t ST_GAP   = 2'd2;

    // Counter width able to hold n-1, never narrower than one bit.
    function automatic int cnt_width(input int n);
        if (n <= 2) begin
            return 1;
        end
        return $clog2(n);
    endfunction

endpackage

// File: rtl/piso_serializer.sv
// MSB-first serializer: valid/ready word load, one bit per clock, done pulse, optional idle gap.
module piso_serializer
    import piso_pkg::*;
#(
    parameter int WIDTH = SER_WIDTH,
    parameter int GAP   = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_in,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             serial_out,
    output logic             bit_valid,
    output logic             done
);

    localparam int BCW = cnt_width(WIDTH);
    localparam int GCW = cnt_width(GAP);

    localparam logic [BCW-1:0] BIT_RELOAD = BCW'(WIDTH - 1);
    localparam logic [GCW-1:0] GAP_RELOAD = (GAP > 0) ? GCW'(GAP - 1) : '0;

    state_t           state_reg;
    state_t           state_next;
    logic [WIDTH-1:0] shift_reg;
    logic [WIDTH-1:0] shift_next;
    logic [WIDTH-1:0] shift_left;
    logic [BCW-1:0]   bit_cnt_reg;
    logic [BCW-1:0]   bit_cnt_next;
    logic [GCW-1:0]   gap_cnt_reg;
    logic [GCW-1:0]   gap_cnt_next;
    logic             done_reg;
    logic             done_next;

    // Left shift with zero fill, MSB leaves first.
    assign shift_left[0] = 1'b0;
    generate
        for (genvar gi = 1; gi < WIDTH; gi++) begin : g_shift
            assign shift_left[gi] = shift_reg[gi-1];
        end
    endgenerate

    always_comb begin
        state_next   = state_reg;
        shift_next   = shift_reg;
        bit_cnt_next = bit_cnt_reg;
        gap_cnt_next = gap_cnt_reg;
        done_next    = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (load_valid) begin
                    shift_next   = data_in;
                    bit_cnt_next = BIT_RELOAD;
                    state_next   = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                shift_next = shift_left;
                if (bit_cnt_reg == '0) begin
                    done_next = 1'b1;
                    if (GAP > 0) begin
                        gap_cnt_next = GAP_RELOAD;
                        state_next   = ST_GAP;
                    end else begin
                        state_next = ST_IDLE;
                    end
                end else begin
                    bit_cnt_next = bit_cnt_reg - 1'b1;
                end
            end
            ST_GAP: begin
                if (gap_cnt_reg == '0) begin
                    state_next = ST_IDLE;
                end else begin
                    gap_cnt_next = gap_cnt_reg - 1'b1;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg   <= ST_IDLE;
            shift_reg   <= '0;
            bit_cnt_reg <= '0;
            gap_cnt_reg <= '0;
            done_reg    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            shift_reg   <= shift_next;
            bit_cnt_reg <= bit_cnt_next;
            gap_cnt_reg <= gap_cnt_next;
            done_reg    <= done_next;
        end
    end

    // Outputs decode registered state only; nothing flows combinationally from inputs.
    assign load_ready = (state_reg == ST_IDLE);
    assign bit_valid  = (state_reg == ST_SHIFT);
    assign serial_out = (state_reg == ST_SHIFT) && shift_reg[WIDTH-1];
    assign done       = done_reg;

endmodule

// File: tb/tb_piso_serializer.sv
// Directed bench for piso_serializer: three parameterisations, bit scoreboard, chained SIPO model.
module tb_piso_serializer;
    import piso_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic [3:0] d_g1, d_g0;
    logic [7:0] d_w8;
    logic       lv_g1, lv_g0, lv_w8;
    logic       rdy_g1, so_g1, bv_g1, dn_g1;
    logic       rdy_g0, so_g0, bv_g0, dn_g0;
    logic       rdy_w8, so_w8, bv_w8, dn_w8;

    int passed = 0;
    int total  = 0;

    bit q_g1[$];
    bit q_g0[$];
    bit q_w8[$];

    logic [3:0] sipo = 4'b0;

    piso_serializer #(.WIDTH(SER_WIDTH), .GAP(1)) dut_g1 (
        .clk(clk), .reset(reset), .data_in(d_g1), .load_valid(lv_g1),
        .load_ready(rdy_g1), .serial_out(so_g1), .bit_valid(bv_g1), .done(dn_g1)
    );

    piso_serializer #(.WIDTH(4), .GAP(0)) dut_g0 (
        .clk(clk), .reset(reset), .data_in(d_g0), .load_valid(lv_g0),
        .load_ready(rdy_g0), .serial_out(so_g0), .bit_valid(bv_g0), .done(dn_g0)
    );

    piso_serializer #(.WIDTH(8), .GAP(3)) dut_w8 (
        .clk(clk), .reset(reset), .data_in(d_w8), .load_valid(lv_w8),
        .load_ready(rdy_w8), .serial_out(so_w8), .bit_valid(bv_w8), .done(dn_w8)
    );

    // Downstream 4-bit SIPO: shifts every clock.
    always @(posedge clk) sipo <= {sipo[2:0], so_g1};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic obs_g1(input string tag, input logic so, input logic bv, input logic dn, input logic rdy);
        chk({tag, "_so"}, 32'(so_g1), 32'(so));
        chk({tag, "_bv"}, 32'(bv_g1), 32'(bv));
        chk({tag, "_done"}, 32'(dn_g1), 32'(dn));
        chk({tag, "_rdy"}, 32'(rdy_g1), 32'(rdy));
    endtask

    task automatic push4(inout bit q[$], input logic [3:0] w);
        for (int i = 3; i >= 0; i--) q.push_back(w[i]);
    endtask

    // Scoreboard monitors: every valid bit must match the next expected bit.
    always @(negedge clk) begin
        if (bv_g1 === 1'b1) begin
            chk("g1_sb_avail", 32'(q_g1.size() != 0), 32'd1);
            if (q_g1.size() != 0) chk("g1_bit", 32'(so_g1), 32'(q_g1.pop_front()));
        end
    end

    always @(negedge clk) begin
        if (bv_g0 === 1'b1) begin
            chk("g0_sb_avail", 32'(q_g0.size() != 0), 32'd1);
            if (q_g0.size() != 0) chk("g0_bit", 32'(so_g0), 32'(q_g0.pop_front()));
        end
    end

    always @(negedge clk) begin
        if (bv_w8 === 1'b1) begin
            chk("w8_sb_avail", 32'(q_w8.size() != 0), 32'd1);
            if (q_w8.size() != 0) chk("w8_bit", 32'(so_w8), 32'(q_w8.pop_front()));
        end
    end

    initial begin
        logic [3:0] w;
        logic [3:0] wa;
        logic [3:0] wb;
        logic [7:0] w8;
        logic       eso;
        int         ndone;

        reset = 1'b1;
        d_g1 = '0; d_g0 = '0; d_w8 = '0;
        lv_g1 = 1'b0; lv_g0 = 1'b0; lv_w8 = 1'b0;
        step();
        step();
        obs_g1("reset", 1'b0, 1'b0, 1'b0, 1'b1);
        chk("reset_g0_rdy", 32'(rdy_g0), 32'd1);
        chk("reset_w8_rdy", 32'(rdy_w8), 32'd1);
        chk("reset_w8_bv", 32'(bv_w8), 32'd0);
        reset = 1'b0;
        step();

        // Single word 1011, GAP=1
        w = 4'b1011;
        d_g1 = w; lv_g1 = 1'b1; push4(q_g1, w);
        step();
        lv_g1 = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            eso = (k <= 4) ? w[4-k] : 1'b0;
            obs_g1($sformatf("a_c%0d", k), eso, k <= 4, k == 5, k == 6);
            if (k == 5) chk("a_sipo", 32'(sipo), 32'(w));
            step();
        end

        // load_valid held high across two words
        wa = 4'hA; wb = 4'h5;
        d_g1 = wa; lv_g1 = 1'b1; push4(q_g1, wa); push4(q_g1, wb);
        step();
        d_g1 = wb;
        ndone = 0;
        for (int k = 1; k <= 12; k++) begin
            if (k <= 4) eso = wa[4-k];
            else if (k >= 7 && k <= 10) eso = wb[10-k];
            else eso = 1'b0;
            obs_g1($sformatf("b_c%0d", k), eso, (k <= 4) || (k >= 7 && k <= 10),
                   (k == 5) || (k == 11), (k == 6) || (k == 12));
            if (dn_g1 === 1'b1) ndone++;
            if (k == 7) lv_g1 = 1'b0;
            step();
        end
        chk("b_done_count", 32'(ndone), 32'd2);

        // data_in change and load_valid pulse during SHIFT are ignored
        w = 4'b1011;
        d_g1 = w; lv_g1 = 1'b1; push4(q_g1, w);
        step();
        lv_g1 = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            eso = (k <= 4) ? w[4-k] : 1'b0;
            obs_g1($sformatf("d_c%0d", k), eso, k <= 4, k == 5, k >= 6);
            if (k == 2) begin
                d_g1 = 4'b0100;
                lv_g1 = 1'b1;
            end
            if (k == 4) lv_g1 = 1'b0;
            step();
        end

        // GAP=0 back-to-back F then 0
        d_g0 = 4'hF; lv_g0 = 1'b1; push4(q_g0, 4'hF); push4(q_g0, 4'h0);
        step();
        d_g0 = 4'h0;
        for (int k = 1; k <= 10; k++) begin
            chk($sformatf("g0_c%0d_bv", k), 32'(bv_g0), 32'((k <= 4) || (k >= 6 && k <= 9)));
            chk($sformatf("g0_c%0d_so", k), 32'(so_g0), 32'(k <= 4));
            chk($sformatf("g0_c%0d_done", k), 32'(dn_g0), 32'((k == 5) || (k == 10)));
            chk($sformatf("g0_c%0d_rdy", k), 32'(rdy_g0), 32'((k == 5) || (k == 10)));
            if (k == 6) lv_g0 = 1'b0;
            step();
        end

        // WIDTH=8, GAP=3, word 81
        w8 = 8'h81;
        d_w8 = w8; lv_w8 = 1'b1;
        for (int i = 7; i >= 0; i--) q_w8.push_back(w8[i]);
        step();
        lv_w8 = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            eso = (k <= 8) ? w8[8-k] : 1'b0;
            chk($sformatf("w8_c%0d_so", k), 32'(so_w8), 32'(eso));
            chk($sformatf("w8_c%0d_bv", k), 32'(bv_w8), 32'(k <= 8));
            chk($sformatf("w8_c%0d_done", k), 32'(dn_w8), 32'(k == 9));
            chk($sformatf("w8_c%0d_rdy", k), 32'(rdy_w8), 32'(k == 12));
            step();
        end

        // Reset in cycle T+2 of word 1100: only the first two bits ever appear
        w = 4'b1100;
        d_g1 = w; lv_g1 = 1'b1;
        q_g1.push_back(1'b1); q_g1.push_back(1'b1);
        step();
        lv_g1 = 1'b0;
        obs_g1("e_c1", 1'b1, 1'b1, 1'b0, 1'b0);
        step();
        obs_g1("e_c2", 1'b1, 1'b1, 1'b0, 1'b0);
        reset = 1'b1;
        step();
        reset = 1'b0;
        for (int k = 3; k <= 6; k++) begin
            obs_g1($sformatf("e_c%0d", k), 1'b0, 1'b0, 1'b0, 1'b1);
            step();
        end

        chk("sb_empty_g1", 32'(q_g1.size()), 32'd0);
        chk("sb_empty_g0", 32'(q_g0.size()), 32'd0);
        chk("sb_empty_w8", 32'(q_w8.size()), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
